// File: rtl/tdc_uart_rx.sv
// tdc_uart_rx
// UART receiver (8N1, LSB first) for a TDC's serial output. On top of that it
// assembles measurement frames of the form SYNC_BYTE + FRAME_BYTES payload
// bytes, where the payload is sent MSB first.
//
// Ports
//   clk        : single clock; all logic runs on its rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   byte_data  : last correctly received byte
//   byte_valid : one-cycle strobe marking a new byte_data
//   meas       : last complete measurement (8*FRAME_BYTES bits)
//   meas_valid : one-cycle strobe marking a new meas; it coincides with the
//                byte_valid of the last payload byte
//   frame_err  : one-cycle strobe on a stop-bit error or an inter-byte timeout
//   busy       : bit engine not idle, or the assembler is inside a frame
module tdc_uart_rx #(
   parameter int          CLKS_PER_BIT = 87,
   parameter int          FRAME_BYTES  = 2,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          TIMEOUT_BITS = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx,
   output logic [7:0]               byte_data,
   output logic                     byte_valid,
   output logic [8*FRAME_BYTES-1:0] meas,
   output logic                     meas_valid,
   output logic                     frame_err,
   output logic                     busy
);

   localparam int CW      = $clog2(CLKS_PER_BIT);
   localparam int GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int GW      = $clog2(GAP_MAX + 1);
   localparam int IW      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int MW      = 8 * FRAME_BYTES;

   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_TOP  = GW'(GAP_MAX);
   localparam logic [GW-1:0] GAP_TRIP = GW'(GAP_MAX - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} bit_state_t;
   typedef enum logic       {HUNT, COLLECT} asm_state_t;

   bit_state_t st, st_nxt;
   asm_state_t a_st, a_nxt;

   // ---------------------------------------------------------------- sync
   // sync_ok marks when rxs carries real line data rather than its reset
   // value. rxs_hi only becomes 1 once the real line has been seen high, so a
   // line held low across reset can never look like a start bit.
   logic       rx_meta, rxs, rxs_hi;
   logic [1:0] sync_ok;
   logic       fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         sync_ok <= 2'b00;
         rxs_hi  <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         sync_ok <= {sync_ok[0], 1'b1};
         rxs_hi  <= sync_ok[1] & rxs;
      end
   end

   assign fall = rxs_hi & ~rxs;

   // ---------------------------------------------------------- bit engine
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          cnt_clr, smp, rx_done, stop_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt   = st;
      cnt_clr  = 1'b0;
      smp      = 1'b0;
      rx_done  = 1'b0;
      stop_err = 1'b0;
      case (st)
         IDLE: begin
            if (fall) begin
               st_nxt  = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            if (cnt == HALF) begin
               cnt_clr = 1'b1;
               st_nxt  = rxs ? IDLE : DATA;  // high at mid-start is a glitch
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_clr = 1'b1;
               smp     = 1'b1;
               if (bit_idx == 3'd7) st_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_clr = 1'b1;
               if (rxs) begin
                  rx_done = 1'b1;
                  st_nxt  = IDLE;
               end else begin
                  stop_err = 1'b1;
                  st_nxt   = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (cnt_clr || st == IDLE || st == WAIT_HIGH) cnt <= '0;
         else                                          cnt <= cnt + 1'b1;

         if (st == IDLE || st == START)  bit_idx <= '0;
         else if (smp)                   bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;

         if (smp) shreg <= {rxs, shreg[7:1]};
      end
   end

   // ----------------------------------------------------- frame assembler
   // The assembler acts on rx_done (the cycle before byte_valid) so that
   // meas_valid and byte_valid leave their registers on the same edge.
   logic [IW-1:0] idx;
   logic [GW-1:0] gap;
   logic [MW-1:0] acc, acc_nxt;
   logic          tmo, fin;

   assign acc_nxt = (acc << 8) | MW'(shreg);
   assign fin     = (a_st == COLLECT) && rx_done && (idx == IDX_LAST);
   // A byte landing on the trip cycle wins over the timeout.
   assign tmo     = (a_st == COLLECT) && !rx_done && (gap == GAP_TRIP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) a_st <= HUNT;
      else        a_st <= a_nxt;
   end

   always_comb begin
      a_nxt = a_st;
      case (a_st)
         HUNT:    if (rx_done && shreg == SYNC_BYTE) a_nxt = COLLECT;
         COLLECT: if (stop_err || tmo || fin)        a_nxt = HUNT;
         default: a_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         gap        <= '0;
         acc        <= '0;
         meas       <= '0;
         meas_valid <= 1'b0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= rx_done;
         if (rx_done) byte_data <= shreg;

         // stop error and timeout cannot both be pending as two pulses:
         // they share this single registered strobe
         frame_err <= stop_err | tmo;

         meas_valid <= fin;
         if (fin) meas <= acc_nxt;

         if (a_st != COLLECT || fin) idx <= '0;
         else if (rx_done)           idx <= idx + 1'b1;

         if (a_st != COLLECT)    acc <= '0;
         else if (rx_done)       acc <= acc_nxt;

         // gap counter: idle in HUNT, restarts on every accepted byte, saturates
         if (a_st == HUNT || rx_done) gap <= '0;
         else if (gap != GAP_TOP)     gap <= gap + 1'b1;
      end
   end

   assign busy = (st != IDLE) || (a_st != HUNT);

endmodule

// File: doc/tdc_uart_rx.md
TDC_UART_RX -- requirements
Module: tdc_uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 87, the clk cycles per UART bit (10 MHz / 115200 baud); legal range 8..4095.
REQ-002 SHALL provide parameter FRAME_BYTES, default 2, the number of measurement payload bytes per frame; legal range 1..4.
REQ-003 SHALL provide parameter SYNC_BYTE, default 8'hA5, the frame header value.
REQ-004 SHALL provide parameter TIMEOUT_BITS, default 20, the maximum gap between frame bytes, in bit times.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst_n, input, 1, the reset; asynchronous assert, active-low.
REQ-007 SHALL have port rx, input, 1, the serial line from the TDC transmitter; 8N1, LSB first, idle high, asynchronous to clk.
REQ-008 SHALL have port byte_data, output, 8, the last correctly received byte.
REQ-009 SHALL have port byte_valid, output, 1, a one-cycle strobe marking a new byte_data.
REQ-010 SHALL have port meas, output, 8*FRAME_BYTES, the last complete measurement.
REQ-011 SHALL have port meas_valid, output, 1, a one-cycle strobe marking a new meas.
REQ-012 SHALL have port frame_err, output, 1, a one-cycle strobe on a stop-bit error or an inter-byte timeout.
REQ-013 SHALL have port busy, output, 1, high whenever the bit engine is outside IDLE or the assembler is outside HUNT.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-015 SHALL implement the bit engine states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: on a falling edge of rxs, SHALL go to START and clear the cycle counter.
REQ-017 START: at count CLKS_PER_BIT/2 (integer divide), SHALL go to DATA if rxs=0; if rxs=1 (glitch) SHALL return to IDLE with no strobe.
REQ-018 DATA: SHALL sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first, then go to STOP.
REQ-019 STOP: CLKS_PER_BIT cycles after the last data sample, SHALL check rxs.
REQ-020 STOP with rxs=1: SHALL update byte_data and pulse byte_valid in the next cycle, then go to IDLE.
REQ-021 STOP with rxs=0: SHALL discard the byte, pulse frame_err in the next cycle, and go to WAIT_HIGH.
REQ-022 WAIT_HIGH: SHALL leave only when rxs=1, going to IDLE; no start bit is accepted while rx stays low (break).
REQ-023 SHALL implement the frame assembler states HUNT and COLLECT.
REQ-024 HUNT: a byte equal to SYNC_BYTE SHALL go to COLLECT with the byte index cleared; any other byte SHALL be ignored and raise no error.
REQ-025 COLLECT: payload bytes SHALL be assembled MSB-first; the first payload byte becomes meas[8*FRAME_BYTES-1 -: 8].
REQ-026 COLLECT, on byte index FRAME_BYTES-1: SHALL load meas atomically, pulse meas_valid in the same cycle as that byte's byte_valid, and return to HUNT.
REQ-027 meas SHALL hold its value between frames; partial frames SHALL never alter meas.
REQ-028 COLLECT: a payload byte equal to SYNC_BYTE SHALL be treated as data, not as a resync.
REQ-029 COLLECT timeout: the gap counter SHALL clear on every byte_valid; on reaching TIMEOUT_BITS*CLKS_PER_BIT cycles it SHALL pulse frame_err and return to HUNT.
REQ-030 A stop-bit error during COLLECT SHALL abort the frame to HUNT, with exactly one frame_err pulse.
REQ-031 A timeout and a stop-bit error in the same cycle SHALL produce a single frame_err pulse.
REQ-032 The gap counter SHALL saturate and SHALL NOT run in HUNT.
REQ-033 Counters SHALL be sized ceil(log2()) of their maximum and SHALL never wrap.

Reset
REQ-034 While rst_n=0, SHALL force the bit engine to IDLE, the assembler to HUNT, all counters to 0, synchronizer flops to 1, byte_data=0, meas=0, and byte_valid=meas_valid=frame_err=busy=0.
REQ-035 A reset in mid-byte or mid-frame SHALL discard partial data, with no strobe on deassertion.
REQ-036 After reset deassertion, the first start bit SHALL be recognized only after rxs has been seen high.

Verification
REQ-037 Default parameters; send 0xA5, 0x12, 0x34 back-to-back -> three byte_valid pulses; meas=16'h1234 with one meas_valid pulse coinciding with the third byte_valid.
REQ-038 In HUNT, send 0x00, then 0xA5, 0xA5, 0x07 -> no frame_err; meas=16'hA507.
REQ-039 A 20-cycle low pulse on idle rx -> no byte_valid, no frame_err; busy returns to 0.
REQ-040 Send byte 0x55 with its stop bit held low for 3 bit times -> no byte_valid; one frame_err; next byte accepted only after rx returns high.
REQ-041 Send 0xA5, 0x12, then stay idle for 21 bit times -> one frame_err at 20*87 cycles after the 0x12 byte_valid; meas unchanged.
REQ-042 Assert rst_n=0 during the DATA bit 4 of a payload byte -> all outputs 0; a following complete frame 0xA5, 0xBE, 0xEF gives meas=16'hBEEF.
